// File: rtl/cordic_multimode_pkg.sv
// ============================================================================
// cordic_pkg : shared types, ATAN table and angle-narrowing helper. Rev 1.0
// ============================================================================
`default_nettype none

package cordic_pkg;

  typedef enum logic {
    CORDIC_ROT = 1'b0,
    CORDIC_VEC = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

  localparam int CORDIC_GAIN_Q15 = 53963;

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  function automatic logic [31:0] atan_narrow(input logic [4:0] idx, input int angle_w);
    logic [32:0] sum;
    if (angle_w >= 32) return ATAN_TABLE[idx];
    sum = {1'b0, ATAN_TABLE[idx]} + (33'd1 << (31 - angle_w));
    return 32'(sum >> (32 - angle_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_multimode_if.sv
// ============================================================================
// cordic_multimode_if : request/result bundle of the CORDIC engine. Rev 1.0
// ============================================================================
`default_nettype none

interface cordic_multimode_if #(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16
);
  logic                      start;
  logic                      mode;
  logic signed [WIDTH-1:0]   x;
  logic signed [WIDTH-1:0]   y;
  logic signed [ANGLE_W-1:0] theta;
  logic                      busy;
  logic                      done;
  logic signed [WIDTH+1:0]   xprime;
  logic signed [WIDTH+1:0]   yprime;
  logic signed [ANGLE_W-1:0] zprime;

  modport master (
    output start, mode, x, y, theta,
    input  busy, done, xprime, yprime, zprime
  );

  modport slave (
    input  start, mode, x, y, theta,
    output busy, done, xprime, yprime, zprime
  );
endinterface

`default_nettype wire

// File: rtl/cordic_multimode_stage.sv
// ============================================================================
// cordic_stage : one combinational CORDIC micro-rotation. Rev 1.0
// ============================================================================
`default_nettype none

module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW = 18,
  parameter int ZW = 16,
  parameter int SW = 5
) (
  input  logic signed [XW-1:0] x_in,
  input  logic signed [XW-1:0] y_in,
  input  logic signed [ZW-1:0] z_in,
  input  logic        [SW-1:0] shift,
  input  logic signed [ZW-1:0] atan,
  input  cordic_mode_e         mode,
  output logic signed [XW-1:0] x_out,
  output logic signed [XW-1:0] y_out,
  output logic signed [ZW-1:0] z_out
);
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic                 ccw;

  always_comb begin
    x_sh = x_in >>> shift;
    y_sh = y_in >>> shift;
    ccw  = (mode == CORDIC_ROT) ? ~z_in[ZW-1] : y_in[XW-1];
    if (ccw) begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan;
    end else begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_multimode.sv
// ============================================================================
// cordic_multimode : iterative rotation/vectoring CORDIC, one step per clock. Rev 1.0
// ============================================================================
`default_nettype none

module cordic_multimode
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16,
  parameter int ITER    = 14
) (
  input  logic               clk,
  input  logic               reset,
  cordic_multimode_if.slave  bus
);
  localparam int XW = WIDTH + 2;
  localparam int CW = 5;
  localparam logic signed [ANGLE_W-1:0] QUARTER = ANGLE_W'(1) << (ANGLE_W - 2);

  cordic_state_e             state;
  cordic_mode_e              mode_reg;
  logic        [CW-1:0]      iter_cnt;
  logic signed [XW-1:0]      x_acc, y_acc;
  logic signed [ANGLE_W-1:0] z_acc;
  logic                      busy_reg, done_reg;
  logic signed [XW-1:0]      x_res, y_res;
  logic signed [ANGLE_W-1:0] z_res;

  logic signed [XW-1:0]      x_pre, y_pre;
  logic signed [ANGLE_W-1:0] z_pre;
  logic signed [XW-1:0]      x_nxt, y_nxt;
  logic signed [ANGLE_W-1:0] z_nxt;
  logic signed [ANGLE_W-1:0] atan_val;

  assign atan_val = ANGLE_W'(atan_narrow(iter_cnt, ANGLE_W));

  // Fold the start vector into the right half-plane (+/-90 deg) where CORDIC converges
  always_comb begin
    x_pre = x_acc;
    y_pre = y_acc;
    z_pre = z_acc;
    if (mode_reg == CORDIC_ROT) begin
      if (z_acc > QUARTER) begin
        x_pre = -y_acc;
        y_pre = x_acc;
        z_pre = z_acc - QUARTER;
      end else if (z_acc < -QUARTER) begin
        x_pre = y_acc;
        y_pre = -x_acc;
        z_pre = z_acc + QUARTER;
      end
    end else if (x_acc[XW-1]) begin
      if (!y_acc[XW-1]) begin
        x_pre = y_acc;
        y_pre = -x_acc;
        z_pre = z_acc + QUARTER;
      end else begin
        x_pre = -y_acc;
        y_pre = x_acc;
        z_pre = z_acc - QUARTER;
      end
    end
  end

  cordic_stage #(
    .XW (XW),
    .ZW (ANGLE_W),
    .SW (CW)
  ) u_stage (
    .x_in  (x_acc),
    .y_in  (y_acc),
    .z_in  (z_acc),
    .shift (iter_cnt),
    .atan  (atan_val),
    .mode  (mode_reg),
    .x_out (x_nxt),
    .y_out (y_nxt),
    .z_out (z_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mode_reg <= CORDIC_ROT;
      iter_cnt <= '0;
      x_acc    <= '0;
      y_acc    <= '0;
      z_acc    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      x_res    <= '0;
      y_res    <= '0;
      z_res    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_acc    <= {{2{bus.x[WIDTH-1]}}, bus.x};
            y_acc    <= {{2{bus.y[WIDTH-1]}}, bus.y};
            z_acc    <= bus.theta;
            mode_reg <= cordic_mode_e'(bus.mode);
            busy_reg <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          x_acc    <= x_pre;
          y_acc    <= y_pre;
          z_acc    <= z_pre;
          iter_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          x_acc <= x_nxt;
          y_acc <= y_nxt;
          z_acc <= z_nxt;
          if (iter_cnt == CW'(ITER - 1)) begin
            iter_cnt <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            x_res    <= x_nxt;
            y_res    <= y_nxt;
            z_res    <= z_nxt;
            state    <= DONE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.xprime = x_res;
  assign bus.yprime = y_res;
  assign bus.zprime = z_res;

endmodule

`default_nettype wire

// File: tb/tb_cordic_multimode.sv
// ============================================================================
// tb_cordic_multimode : randomized bench against a real-arithmetic trig model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cordic_multimode;
  localparam int  WIDTH   = 16;
  localparam int  ANGLE_W = 16;
  localparam int  ITER    = 14;
  localparam real PI      = 3.14159265358979323846;
  localparam int  TURN    = 1 << ANGLE_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  real  gain;

  cordic_multimode_if #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W)) bus_if ();

  cordic_multimode #(
    .WIDTH   (WIDTH),
    .ANGLE_W (ANGLE_W),
    .ITER    (ITER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint exp,
                       input longint tol, input longint wrap);
    longint diff;
    diff = obs - exp;
    if (wrap != 0) begin
      diff = diff % wrap;
      if (diff > wrap / 2) diff -= wrap;
      else if (diff < -(wrap / 2)) diff += wrap;
    end
    checks++;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal CORDIC outcome from trigonometry, with the uncompensated gain applied
  task automatic model(input bit m, input int xi, input int yi, input int th,
                       output int ex, output int ey, output int ez);
    real ang;
    ang = real'(th) * 2.0 * PI / real'(TURN);
    if (!m) begin
      ex = int'(gain * (real'(xi) * $cos(ang) - real'(yi) * $sin(ang)));
      ey = int'(gain * (real'(xi) * $sin(ang) + real'(yi) * $cos(ang)));
      ez = 0;
    end else begin
      ex = int'(gain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)));
      ey = 0;
      ez = th + int'($atan2(real'(yi), real'(xi)) * real'(TURN) / (2.0 * PI));
    end
  endtask

  task automatic drive(input bit m, input int xi, input int yi, input int th, input bit st);
    bus_if.mode  = m;
    bus_if.x     = WIDTH'(xi);
    bus_if.y     = WIDTH'(yi);
    bus_if.theta = ANGLE_W'(th);
    bus_if.start = st;
  endtask

  task automatic launch(input string tag, input bit m, input int xi, input int yi, input int th);
    drive(m, xi, yi, th, 1'b1);
    tick();
    bus_if.start = 1'b0;
    check({tag, ".busy"}, longint'(bus_if.busy), 1, 0, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus_if.done && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input bit m, input int xi, input int yi,
                              input int th, input int tol, input int ztol);
    int ex, ey, ez;
    model(m, xi, yi, th, ex, ey, ez);
    check({tag, ".x"}, longint'(int'(bus_if.xprime)), ex, tol, 0);
    check({tag, ".y"}, longint'(int'(bus_if.yprime)), ey, tol, 0);
    check({tag, ".z"}, longint'(int'(bus_if.zprime)), ez, ztol, TURN);
  endtask

  task automatic run_check(input string tag, input bit m, input int xi, input int yi,
                           input int th, input int tol, input int ztol);
    int n;
    launch(tag, m, xi, yi, th);
    wait_done(n);
    check({tag, ".lat"}, n, ITER + 1, 0, 0);
    check_result(tag, m, xi, yi, th, tol, ztol);
    tick();
    check({tag, ".pulse"}, longint'(bus_if.done), 0, 0, 0);
  endtask

  initial begin
    int n, cnt, xi, yi, th;
    bit m;

    gain = 1.0;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));

    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (3) tick();
    check("rst.busy", longint'(bus_if.busy), 0, 0, 0);
    check("rst.done", longint'(bus_if.done), 0, 0, 0);
    check("rst.x", longint'(int'(bus_if.xprime)), 0, 0, 0);
    check("rst.y", longint'(int'(bus_if.yprime)), 0, 0, 0);
    check("rst.z", longint'(int'(bus_if.zprime)), 0, 0, 0);
    reset = 1'b1;
    tick();

    run_check("rot45",  1'b0,  10000,    0,  16'h2000, 8, 6);
    run_check("rot180", 1'b0,  10000,    0,    -32768, 8, 6);
    run_check("vec345", 1'b1,   3000, 4000,         0, 8, 6);
    run_check("vecleft",1'b1, -10000,    0,         0, 8, 6);
    run_check("vecq3",  1'b1,  -6000,-8000,      1000, 8, 8);
    run_check("rotneg", 1'b0,   7000, -3000,   -20000, 8, 6);

    // start pulses mid-run and on the done cycle must both be dropped
    launch("hs", 1'b0, 10000, 5000, 16'h1000);
    repeat (5) tick();
    drive(1'b1, -9000, 1234, 5555, 1'b1);
    tick();
    bus_if.start = 1'b0;
    check("hs.mid_busy", longint'(bus_if.busy), 1, 0, 0);
    wait_done(n);
    check("hs.mid_lat", n, ITER + 1 - 6, 0, 0);
    check_result("hs.a", 1'b0, 10000, 5000, 16'h1000, 8, 6);
    drive(1'b1, -9000, 1234, 5555, 1'b1);
    tick();
    bus_if.start = 1'b0;
    check("hs.done_busy", longint'(bus_if.busy), 0, 0, 0);
    check("hs.done_done", longint'(bus_if.done), 0, 0, 0);
    check_result("hs.hold", 1'b0, 10000, 5000, 16'h1000, 8, 6);
    run_check("hs.b", 1'b1, -9000, 1234, 5555, 8, 8);

    // reset mid-run discards the partial result
    launch("mrst", 1'b0, 12000, -4000, 9000);
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst.busy", longint'(bus_if.busy), 0, 0, 0);
    check("mrst.done", longint'(bus_if.done), 0, 0, 0);
    check("mrst.x", longint'(int'(bus_if.xprime)), 0, 0, 0);
    check("mrst.y", longint'(int'(bus_if.yprime)), 0, 0, 0);
    check("mrst.z", longint'(int'(bus_if.zprime)), 0, 0, 0);
    cnt = 0;
    repeat (ITER + 4) begin
      tick();
      if (bus_if.done) cnt++;
    end
    check("mrst.no_done", cnt, 0, 0, 0);
    run_check("mrst.fresh", 1'b0, 12000, -4000, 9000, 8, 6);

    for (int k = 0; k < 24; k++) begin
      m  = 1'($urandom_range(0, 1));
      th = int'($urandom_range(0, TURN - 1)) - TURN / 2;
      do begin
        xi = int'($urandom_range(0, 40000)) - 20000;
        yi = int'($urandom_range(0, 40000)) - 20000;
      end while (m && (xi * xi + yi * yi < 8000 * 8000));
      run_check($sformatf("rnd%0d", k), m, xi, yi, th, 24, m ? 24 : 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_multimode.md
Name: cordic_multimode

Overview:
Iterative, parametrised CORDIC engine, one micro-rotation per clock. It succeeds the 16-bit rotation-only block. Adds configurable width and iteration count, a runtime mode select (rotation or vectoring), full-circle angle coverage via quadrant pre-rotation, and a start/busy/done handshake. It sits in the datapath as a shared trig/magnitude/phase unit.

Parameters:
WIDTH, 16, signed x/y input width; internal x/y registers and outputs are WIDTH+2 bits for CORDIC gain headroom
ANGLE_W, 16, signed binary-angle width; 2^ANGLE_W counts = 360 deg, 0x4000 = +90 deg at default
ITER, 14, micro-rotation count; legal 4..min(ANGLE_W,24)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = rotation, 1 = vectoring; captured with start
x  input  WIDTH  signed initial x
y  input  WIDTH  signed initial y
theta  input  ANGLE_W  signed initial angle (z0)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results valid on this cycle and held until the next accept
xprime  output  WIDTH+2  signed result x (gain K~1.6468 not compensated)
yprime  output  WIDTH+2  signed result y
zprime  output  ANGLE_W  signed result angle, wraps modulo 360 deg

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; busy=0, done=0, xprime=yprime=zprime=0; iteration counter=0. Takes priority over everything, including mid-run; the partial result is discarded.
- States: IDLE -> (start) LOAD -> RUN (ITER cycles) -> DONE (1 cycle) -> IDLE. A start in DONE is not accepted. The next accept is on the following IDLE cycle.
- Latency: start sampled high in IDLE at edge N gives done=1 in the cycle after edge N+ITER+1. busy is high across LOAD and RUN.
- start while busy or in DONE: ignored, no queueing. x/y/theta/mode changes after accept have no effect.
- LOAD applies sign extension to WIDTH+2 bits, then quadrant pre-rotation:
  - rotation, theta > +90 deg: x0=-y, y0=x, z0=theta-90.
  - rotation, theta < -90 deg: x0=y, y0=-x, z0=theta+90.
  - vectoring, x<0 and y>=0: x0=y, y0=-x, z0=theta+90.
  - vectoring, x<0 and y<0: x0=-y, y0=x, z0=theta-90.
  - otherwise: x0=x, y0=y, z0=theta.
  - -180 deg (0x8000 at default) takes the < -90 branch.
- RUN iteration i = 0..ITER-1:
  - d=+1 if (rotation and z>=0) or (vectoring and y<0); else d=-1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - Arithmetic shifts. Two's-complement wrap on z is intentional. There is no saturation on x/y; headroom makes it unnecessary.
- Results: rotation gives (K*(x cos z - y sin z), K*(x sin z + y cos z), ~0). Vectoring gives (K*sqrt(x^2+y^2), ~0, theta+atan2(y,x)).
- x=y=0 in vectoring mode: outputs 0, 0, theta +/- residual. This is not an error.
- Outputs register on the DONE transition and hold through IDLE.

Decomposition:
- Package cordic_pkg:
  - 32-entry ATAN table at 32-bit angle precision; entry i = round(atan(2^-i)/(2*pi)*2^32). Narrowed with rounding to ANGLE_W by a package function.
  - mode enum {CORDIC_ROT, CORDIC_VEC}.
  - state enum {IDLE, LOAD, RUN, DONE}.
  - localparam CORDIC_GAIN_Q15 = 53963.
- Sub-module cordic_stage: one combinational micro-rotation. Inputs x, y, z, shift i, atan value, mode; outputs the next x/y/z.
- The top level owns the FSM, counter, pre-rotation and output registers.

Test Plan:
- Rotation: x=10000, y=0, theta=0x2000 (45 deg) -> done exactly ITER+2 cycles after the start edge; xprime ~= yprime ~= 11645 +/-4; zprime ~= 0 +/-4.
- Rotation, wide angle: x=10000, y=0, theta=0x8000 (-180 deg) -> xprime ~= -16468 +/-4, yprime ~= 0 +/-4.
- Vectoring: x=3000, y=4000, theta=0 -> xprime ~= 8234 +/-4, yprime ~= 0 +/-4, zprime ~= 9672 (53.13 deg) +/-4.
- Vectoring, left half-plane: x=-10000, y=0, theta=0 -> xprime ~= 16468 +/-4; zprime within +/-4 of 0x8000 (accept wrap both sides).
- Handshake: pulse start again at mid-run and on the done cycle -> both ignored. Start on the following IDLE cycle -> accepted with the same latency; outputs hold between runs.
- Reset: drive reset=0 for one cycle at iteration 5 -> next cycle busy=0, done=0, outputs 0, no done pulse. A fresh start afterwards gives the correct result.
